// File: rtl/lsq_mem_scheduler_if.sv
// Handshake bundle between the load/store queues, the data-memory port and writeback.
// The scheduler uses the master modport; the queues, memory and writeback side use slave.
interface lsq_mem_scheduler_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic                    ld_q_empty;
  logic [AddressWidth-1:0] ld_q_data;
  logic                    ld_q_pop;
  logic                    st_q_empty;
  logic                    st_q_full;
  logic [AddressWidth-1:0] st_q_data;
  logic [DataWidth-1:0]    st_q_wdata;
  logic                    st_q_pop;
  logic                    mem_req;
  logic                    mem_we;
  logic [AddressWidth-1:0] mem_addr;
  logic [DataWidth-1:0]    mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DataWidth-1:0]    mem_rdata;
  logic                    ld_resp_valid;
  logic [DataWidth-1:0]    ld_resp_data;
  logic                    ld_resp_err;
  logic                    busy;

  modport master (
    input  ld_q_empty, ld_q_data, st_q_empty, st_q_full, st_q_data, st_q_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_q_pop, st_q_pop, mem_req, mem_we, mem_addr, mem_wdata,
    output ld_resp_valid, ld_resp_data, ld_resp_err, busy
  );

  modport slave (
    output ld_q_empty, ld_q_data, st_q_empty, st_q_full, st_q_data, st_q_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_q_pop, st_q_pop, mem_req, mem_we, mem_addr, mem_wdata,
    input  ld_resp_valid, ld_resp_data, ld_resp_err, busy
  );
endinterface

// File: rtl/lsq_mem_scheduler.sv
// Arbitrates load and store queues onto a single req/gnt data-memory port, one transaction
// in flight; loads win unless a store is starving or the store queue is full.
module lsq_mem_scheduler #(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int StarveLimit   = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  lsq_mem_scheduler_if.master  bus
);

  localparam int SW = $clog2(StarveLimit + 1);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(StarveLimit);
  localparam logic [TW-1:0] TO_LAST    = TW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  state_r;
  logic [SW-1:0]           starve_cnt_r;
  logic [TW-1:0]           timeout_cnt_r;
  logic                    mem_req_r;
  logic                    mem_we_r;
  logic [AddressWidth-1:0] mem_addr_r;
  logic [DataWidth-1:0]    mem_wdata_r;
  logic                    ld_resp_valid_r;
  logic [DataWidth-1:0]    ld_resp_data_r;
  logic                    ld_resp_err_r;
  logic                    busy_r;

  logic                    pick_st_s;
  logic                    pick_ld_s;

  // Arbitration in IDLE; gated by rstn so no entry is popped while reset is held.
  always_comb begin
    pick_st_s = 1'b0;
    pick_ld_s = 1'b0;
    if ((state_r == S_IDLE) && rstn) begin
      if (!bus.st_q_empty &&
          (bus.ld_q_empty || bus.st_q_full || (starve_cnt_r == STARVE_MAX))) begin
        pick_st_s = 1'b1;
      end else if (!bus.ld_q_empty) begin
        pick_ld_s = 1'b1;
      end else begin
        pick_st_s = 1'b0;
        pick_ld_s = 1'b0;
      end
    end else begin
      pick_st_s = 1'b0;
      pick_ld_s = 1'b0;
    end
  end

  assign bus.ld_q_pop = pick_ld_s;
  assign bus.st_q_pop = pick_st_s;

  // Scheduler FSM with its counters and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r         <= S_IDLE;
      starve_cnt_r    <= {SW{1'b0}};
      timeout_cnt_r   <= {TW{1'b0}};
      mem_req_r       <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= {AddressWidth{1'b0}};
      mem_wdata_r     <= {DataWidth{1'b0}};
      ld_resp_valid_r <= 1'b0;
      ld_resp_data_r  <= {DataWidth{1'b0}};
      ld_resp_err_r   <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      ld_resp_valid_r <= 1'b0;
      ld_resp_err_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_st_s) begin
            mem_addr_r   <= bus.st_q_data;
            mem_wdata_r  <= bus.st_q_wdata;
            mem_we_r     <= 1'b1;
            mem_req_r    <= 1'b1;
            busy_r       <= 1'b1;
            starve_cnt_r <= {SW{1'b0}};
            state_r      <= S_REQ;
          end else if (pick_ld_s) begin
            mem_addr_r   <= bus.ld_q_data;
            mem_wdata_r  <= {DataWidth{1'b0}};
            mem_we_r     <= 1'b0;
            mem_req_r    <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= S_REQ;
            // Only loads that bypass a waiting store count toward starvation.
            if (bus.st_q_empty) begin
              starve_cnt_r <= {SW{1'b0}};
            end else if (starve_cnt_r != STARVE_MAX) begin
              starve_cnt_r <= starve_cnt_r + SW'(1);
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_r <= 1'b0;
            if (mem_we_r) begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              timeout_cnt_r <= {TW{1'b0}};
              state_r       <= S_WAIT;
            end
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            ld_resp_valid_r <= 1'b1;
            ld_resp_data_r  <= bus.mem_rdata;
            ld_resp_err_r   <= 1'b0;
            busy_r          <= 1'b0;
            state_r         <= S_IDLE;
          end else if (timeout_cnt_r == TO_LAST) begin
            ld_resp_valid_r <= 1'b1;
            ld_resp_data_r  <= {DataWidth{1'b0}};
            ld_resp_err_r   <= 1'b1;
            busy_r          <= 1'b0;
            state_r         <= S_IDLE;
          end else begin
            // Stays below TO_LAST here, so the increment can never wrap.
            timeout_cnt_r <= timeout_cnt_r + TW'(1);
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req       = mem_req_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.ld_resp_valid = ld_resp_valid_r;
  assign bus.ld_resp_data  = ld_resp_data_r;
  assign bus.ld_resp_err   = ld_resp_err_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
// Directed self-checking bench for lsq_mem_scheduler (StarveLimit=4, TimeoutCycles=64).
module tb_lsq_mem_scheduler;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  lsq_mem_scheduler_if #(.AddressWidth(32), .DataWidth(32)) bus ();

  lsq_mem_scheduler #(
    .AddressWidth(32), .DataWidth(32), .StarveLimit(4), .TimeoutCycles(64)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_q_empty = 1'b1;
    bus.ld_q_data  = 32'h0;
    bus.st_q_empty = 1'b1;
    bus.st_q_full  = 1'b0;
    bus.st_q_data  = 32'h0;
    bus.st_q_wdata = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [101:0] outs;
    idle_inputs();
    bus.ld_q_empty = 1'b0;
    bus.ld_q_data  = 32'h40;
    bus.st_q_empty = 1'b0;
    bus.st_q_data  = 32'h80;
    rstn = 1'b0;
    tick();
    tick();
    outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ld_resp_valid,
            bus.ld_resp_data, bus.ld_resp_err, bus.busy};
    n_tests++; if (outs !== 102'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b00) begin n_fail++; $display("FAIL reset_no_pop: got %b want 00", {bus.ld_q_pop, bus.st_q_pop}); end
    rstn = 1'b1;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b10) begin n_fail++; $display("FAIL reset_first_pop_load: got %b want 10", {bus.ld_q_pop, bus.st_q_pop}); end
    tick();
    n_tests++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h40}) begin n_fail++; $display("FAIL reset_first_req: got %b/%b/%h want 1/0/40", bus.mem_req, bus.mem_we, bus.mem_addr); end
    do_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    bus.ld_q_empty = 1'b0;
    bus.ld_q_data  = 32'h100;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop, bus.busy} !== 3'b100) begin n_fail++; $display("FAIL load_pop: got %b want 100", {bus.ld_q_pop, bus.st_q_pop, bus.busy}); end
    tick();
    bus.ld_q_empty = 1'b1;
    #1;
    n_tests++; if ({bus.mem_req, bus.mem_we, bus.busy} !== 3'b101) begin n_fail++; $display("FAIL load_req_we_busy: got %b want 101", {bus.mem_req, bus.mem_we, bus.busy}); end
    n_tests++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL load_addr: got %h want 100", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL load_wdata: got %h want 0", bus.mem_wdata); end
    tick();
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL load_req_held: got %b want 1", bus.mem_req); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    n_tests++; if ({bus.mem_req, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL load_req_drop: got %b want 01", {bus.mem_req, bus.busy}); end
    tick();
    n_tests++; if (bus.ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_resp_early: got %b want 0", bus.ld_resp_valid); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    n_tests++; if ({bus.ld_resp_valid, bus.ld_resp_err, bus.busy} !== 3'b100) begin n_fail++; $display("FAIL load_resp_flags: got %b want 100", {bus.ld_resp_valid, bus.ld_resp_err, bus.busy}); end
    n_tests++; if (bus.ld_resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_resp_data: got %h want deadbeef", bus.ld_resp_data); end
    tick();
    n_tests++; if (bus.ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_resp_pulse: got %b want 0", bus.ld_resp_valid); end
  endtask

  task automatic test_single_store();
    int bad;
    bad = 0;
    do_reset();
    bus.st_q_empty = 1'b0;
    bus.st_q_data  = 32'h200;
    bus.st_q_wdata = 32'h12345678;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b01) begin n_fail++; $display("FAIL store_pop: got %b want 01", {bus.ld_q_pop, bus.st_q_pop}); end
    tick();
    bus.st_q_empty = 1'b1;
    bus.st_q_data  = 32'h0;
    bus.st_q_wdata = 32'h0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'h12345678}) bad++;
      if (bus.ld_resp_valid !== 1'b0) bad++;
      bus.mem_gnt = (i == 3);
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL store_req_hold: got %0d bad cycles want 0", bad); end
    n_tests++; if ({bus.mem_req, bus.busy, bus.ld_resp_valid} !== 3'b000) begin n_fail++; $display("FAIL store_done: got %b want 000", {bus.mem_req, bus.busy, bus.ld_resp_valid}); end
    tick();
    n_tests++; if (bus.ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_resp: got %b want 0", bus.ld_resp_valid); end
  endtask

  task automatic test_starvation();
    logic [9:0] sel;
    int n;
    int dual;
    sel  = 10'h0;
    n    = 0;
    dual = 0;
    do_reset();
    bus.ld_q_empty = 1'b0;
    bus.ld_q_data  = 32'h300;
    bus.st_q_empty = 1'b0;
    bus.st_q_data  = 32'h400;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    #1;
    for (int c = 0; c < 200 && n < 10; c++) begin
      if (bus.ld_q_pop && bus.st_q_pop) dual++;
      else if (bus.st_q_pop) begin sel = {sel[8:0], 1'b1}; n++; end
      else if (bus.ld_q_pop) begin sel = {sel[8:0], 1'b0}; n++; end
      tick();
    end
    n_tests++; if (n !== 10) begin n_fail++; $display("FAIL starve_count: got %0d pops want 10", n); end
    n_tests++; if (sel !== 10'b0000100001) begin n_fail++; $display("FAIL starve_order: got %b want 0000100001 (1=store)", sel); end
    n_tests++; if (dual !== 0) begin n_fail++; $display("FAIL starve_dual_pop: got %0d want 0", dual); end
    do_reset();
  endtask

  task automatic test_store_full();
    do_reset();
    bus.ld_q_empty = 1'b0;
    bus.ld_q_data  = 32'h500;
    bus.st_q_empty = 1'b0;
    bus.st_q_data  = 32'h600;
    bus.st_q_wdata = 32'hA5A5A5A5;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b10) begin n_fail++; $display("FAIL full_pre_load: got %b want 10", {bus.ld_q_pop, bus.st_q_pop}); end
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.st_q_full  = 1'b1;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b01) begin n_fail++; $display("FAIL full_pick_store: got %b want 01", {bus.ld_q_pop, bus.st_q_pop}); end
    tick();
    bus.st_q_full = 1'b0;
    n_tests++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h600, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL full_store_req: got %b/%h/%h want 1/600/a5a5a5a5", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    #1;
    n_tests++; if ({bus.ld_q_pop, bus.st_q_pop} !== 2'b10) begin n_fail++; $display("FAIL full_after_load: got %b want 10", {bus.ld_q_pop, bus.st_q_pop}); end
    do_reset();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    bus.ld_q_empty = 1'b0;
    bus.ld_q_data  = 32'h700;
    #1;
    n_tests++; if (bus.ld_q_pop !== 1'b1) begin n_fail++; $display("FAIL timeout_pop: got %b want 1", bus.ld_q_pop); end
    tick();
    bus.ld_q_empty = 1'b1;
    bus.mem_gnt    = 1'b1;
    tick();
    bus.mem_gnt   = 1'b0;
    bus.mem_rdata = 32'hFFFF0000;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (bus.ld_resp_valid !== 1'b0 || bus.busy !== 1'b1) early++;
    end
    n_tests++; if (early !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
    tick();
    n_tests++; if ({bus.ld_resp_valid, bus.ld_resp_err, bus.busy} !== 3'b110) begin n_fail++; $display("FAIL timeout_flags: got %b want 110", {bus.ld_resp_valid, bus.ld_resp_err, bus.busy}); end
    n_tests++; if (bus.ld_resp_data !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h want 0", bus.ld_resp_data); end
    tick();
    n_tests++; if ({bus.ld_resp_valid, bus.ld_resp_err} !== 2'b00) begin n_fail++; $display("FAIL timeout_pulse: got %b want 00", {bus.ld_resp_valid, bus.ld_resp_err}); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    idle_inputs();
    test_reset();
    test_single_load();
    test_single_store();
    test_starvation();
    test_store_full();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
